// File: rtl/sysu_xor_share_ctrl.sv
// Round-robin controller sharing one quad 2-input XOR among four requesters.
// Captures the winner's operands, waits LAT cycles, then holds the result until ACK.
module sysu_xor_share_ctrl #(
    parameter int LAT = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  REQ,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        ACK,
    output logic [3:0]  GNT,
    output logic [3:0]  Y,
    output logic        VALID,
    output logic [1:0]  ID,
    output logic        BUSY
);

    // A latency of 0 behaves as 1; anything above the 3-bit counter range saturates.
    localparam logic [2:0] LAT_EFF = (LAT < 1) ? 3'd1 :
                                     (LAT > 7) ? 3'd7 : 3'(LAT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  y_q, y_d;
    logic        valid_q, valid_d;
    logic [1:0]  id_q, id_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  pri_q, pri_d;
    logic [3:0]  op_a_q, op_a_d;
    logic [3:0]  op_b_q, op_b_d;

    logic        win_found;
    logic [1:0]  win_idx;
    logic [1:0]  cand;

    // Scan requesters starting at the priority pointer; first set bit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = pri_q;
        cand      = pri_q;
        for (int i = 0; i < 4; i++) begin
            cand = pri_q + 2'(i);
            if (!win_found && REQ[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            gnt_q   <= 4'b0000;
            y_q     <= 4'b0000;
            valid_q <= 1'b0;
            id_q    <= 2'b00;
            cnt_q   <= 3'd0;
            pri_q   <= 2'b00;
            op_a_q  <= 4'b0000;
            op_b_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            pri_q   <= pri_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = 4'b0000;
        y_d     = y_q;
        valid_d = valid_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        pri_d   = pri_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    op_a_d  = A[{win_idx, 2'b00} +: 4];
                    op_b_d  = B[{win_idx, 2'b00} +: 4];
                    id_d    = win_idx;
                    gnt_d   = 4'b0001 << win_idx;
                    cnt_d   = LAT_EFF;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 3'd1) begin
                    y_d     = op_a_q ^ op_b_q;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_DONE: begin
                // Y is deliberately left alone on ACK so the last result stays readable.
                if (ACK) begin
                    valid_d = 1'b0;
                    pri_d   = id_q + 2'd1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign GNT   = gnt_q;
    assign Y     = y_q;
    assign VALID = valid_q;
    assign ID    = id_q;
    assign BUSY  = (state_q != ST_IDLE);

endmodule
